// File: rtl/bilinear_scan_ctrl.sv
// rtl/bilinear_scan_ctrl.sv - raster sequencer for the bilinear scaler fetch path
// Walks destination pixels, maps them to clamped source coords/weights, and paces RAM latency.
module bilinear_scan_ctrl #(
    parameter int FRAC_W  = 8,
    parameter int RAM_LAT = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [7:0]           src_width_i,
    input  logic [7:0]           src_height_i,
    input  logic [9:0]           dst_width_i,
    input  logic [9:0]           dst_height_i,
    input  logic [10+FRAC_W-1:0] step_x_i,
    input  logic [10+FRAC_W-1:0] step_y_i,
    output logic [9:0]           coord_x_o,
    output logic [9:0]           coord_y_o,
    output logic [FRAC_W-1:0]    frac_x_o,
    output logic [FRAC_W-1:0]    frac_y_o,
    output logic [9:0]           dst_x_o,
    output logic [9:0]           dst_y_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int STEP_W = 10 + FRAC_W;
    localparam int ACC_W  = STEP_W + 1;
    localparam int IP_W   = ACC_W - FRAC_W;
    localparam int LAT_W  = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RAM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [7:0]        src_w_q, src_w_d;
    logic [7:0]        src_h_q, src_h_d;
    logic [9:0]        dst_w_q, dst_w_d;
    logic [9:0]        dst_h_q, dst_h_d;
    logic [STEP_W-1:0] step_x_q, step_x_d;
    logic [STEP_W-1:0] step_y_q, step_y_d;
    logic [ACC_W-1:0]  acc_x_q, acc_x_d;
    logic [ACC_W-1:0]  acc_y_q, acc_y_d;
    logic [9:0]        dst_x_q, dst_x_d;
    logic [9:0]        dst_y_q, dst_y_d;
    logic [9:0]        coord_x_q, coord_x_d;
    logic [9:0]        coord_y_q, coord_y_d;
    logic [FRAC_W-1:0] frac_x_q, frac_x_d;
    logic [FRAC_W-1:0] frac_y_q, frac_y_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;

    // Saturating add: a pinned accumulator always lands in the clamp region.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [STEP_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(b);
        sat_add = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    // Returns {coord, frac}; positions at or beyond the last source pixel clamp with zero weight.
    function automatic logic [10+FRAC_W-1:0] map_axis(input logic [ACC_W-1:0] acc,
                                                      input logic [7:0] dim);
        logic [IP_W-1:0] ip;
        logic [IP_W-1:0] lim;
        ip  = acc[ACC_W-1:FRAC_W];
        lim = IP_W'(dim) - IP_W'(1);
        if (ip >= lim) begin
            map_axis = {lim[9:0], {FRAC_W{1'b0}}};
        end else begin
            map_axis = {ip[9:0], acc[FRAC_W-1:0]};
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        src_w_d   = src_w_q;
        src_h_d   = src_h_q;
        dst_w_d   = dst_w_q;
        dst_h_d   = dst_h_q;
        step_x_d  = step_x_q;
        step_y_d  = step_y_q;
        acc_x_d   = acc_x_q;
        acc_y_d   = acc_y_q;
        dst_x_d   = dst_x_q;
        dst_y_d   = dst_y_q;
        coord_x_d = coord_x_q;
        coord_y_d = coord_y_q;
        frac_x_d  = frac_x_q;
        frac_y_d  = frac_y_q;
        lat_cnt_d = lat_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    src_w_d   = src_width_i;
                    src_h_d   = src_height_i;
                    dst_w_d   = dst_width_i;
                    dst_h_d   = dst_height_i;
                    step_x_d  = step_x_i;
                    step_y_d  = step_y_i;
                    acc_x_d   = '0;
                    acc_y_d   = '0;
                    dst_x_d   = '0;
                    dst_y_d   = '0;
                    coord_x_d = '0;
                    coord_y_d = '0;
                    frac_x_d  = '0;
                    frac_y_d  = '0;
                    lat_cnt_d = '0;
                    if (dst_width_i == 10'd0 || dst_height_i == 10'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    lat_cnt_d = '0;
                    state_d   = S_PRESENT;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end

            S_PRESENT: begin
                if (out_ready_i) begin
                    if (dst_x_q != dst_w_q - 10'd1) begin
                        dst_x_d = dst_x_q + 10'd1;
                        acc_x_d = sat_add(acc_x_q, step_x_q);
                        state_d = S_WAIT;
                    end else if (dst_y_q != dst_h_q - 10'd1) begin
                        dst_x_d = '0;
                        acc_x_d = '0;
                        dst_y_d = dst_y_q + 10'd1;
                        acc_y_d = sat_add(acc_y_q, step_y_q);
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_DONE;
                    end
                    // On the final pixel the accumulators are unchanged, so coords hold.
                    {coord_x_d, frac_x_d} = map_axis(acc_x_d, src_w_q);
                    {coord_y_d, frac_y_d} = map_axis(acc_y_d, src_h_q);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            src_w_q   <= '0;
            src_h_q   <= '0;
            dst_w_q   <= '0;
            dst_h_q   <= '0;
            step_x_q  <= '0;
            step_y_q  <= '0;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            dst_x_q   <= '0;
            dst_y_q   <= '0;
            coord_x_q <= '0;
            coord_y_q <= '0;
            frac_x_q  <= '0;
            frac_y_q  <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            src_w_q   <= src_w_d;
            src_h_q   <= src_h_d;
            dst_w_q   <= dst_w_d;
            dst_h_q   <= dst_h_d;
            step_x_q  <= step_x_d;
            step_y_q  <= step_y_d;
            acc_x_q   <= acc_x_d;
            acc_y_q   <= acc_y_d;
            dst_x_q   <= dst_x_d;
            dst_y_q   <= dst_y_d;
            coord_x_q <= coord_x_d;
            coord_y_q <= coord_y_d;
            frac_x_q  <= frac_x_d;
            frac_y_q  <= frac_y_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign coord_x_o   = coord_x_q;
    assign coord_y_o   = coord_y_q;
    assign frac_x_o    = frac_x_q;
    assign frac_y_o    = frac_y_q;
    assign dst_x_o     = dst_x_q;
    assign dst_y_o     = dst_y_q;
    assign out_valid_o = (state_q == S_PRESENT);
    assign busy_o      = (state_q == S_WAIT) || (state_q == S_PRESENT);
    assign done_o      = (state_q == S_DONE);

endmodule
